// File: rtl/fp_normalize_round.sv
// Post-adder normaliser: shifts the raw mantissa one step per cycle, rounds
// to nearest (ties away from zero) and packs {sign, exp, frac} with ovf/unf flags.
module fp_normalize_round #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 5,
  parameter int BIAS   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+2:0]         in_man,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_fp,
  output logic                      out_ovf,
  output logic                      out_unf,
  output logic [1:0]                dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and the result
  // is held unchanged while out_valid && !out_ready.

  localparam int MAN_W = FRAC_W + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  if (BIAS != (1 << (EXP_W - 1)) - 1) begin : g_bias_check
    $error("fp_normalize_round: BIAS must be 2^(EXP_W-1)-1");
  end

  logic [1:0]              state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic [MAN_W-1:0]        man_q, man_d;
  logic [EXP_W+FRAC_W:0]   out_fp_q, out_fp_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  logic [FRAC_W:0]         frac6;
  logic [EXP_W-1:0]        exp_rnd;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    out_fp_d = out_fp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    frac6    = {1'b0, man_q[FRAC_W:1]} + {{FRAC_W{1'b0}}, man_q[0]};
    exp_rnd  = exp_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          man_d   = in_man;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (man_q == '0 || exp_q == '0) begin
          out_fp_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = S_DONE;
        end else if (exp_q == EXP_MAX) begin
          // Reached only after a carry step bumped the exponent to the max,
          // so a carry-overflow result appears two edges after accept.
          out_fp_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
          state_d  = S_DONE;
        end else if (man_q[MAN_W-1]) begin
          man_d = {1'b0, man_q[MAN_W-1:2], man_q[1] | man_q[0]};
          exp_d = exp_q + 1'b1;
        end else if (man_q[MAN_W-2]) begin
          state_d = S_ROUND;
        end else if (exp_q == EXP_ONE) begin
          out_fp_d = '0;
          unf_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          man_d = {man_q[MAN_W-2:0], 1'b0};
          exp_d = exp_q - 1'b1;
        end
      end
      S_ROUND: begin
        if (frac6[FRAC_W]) begin
          if (exp_rnd == EXP_MAX) begin
            out_fp_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            out_fp_d = {sign_q, exp_rnd, {FRAC_W{1'b0}}};
          end
        end else begin
          out_fp_d = {sign_q, exp_q, frac6[FRAC_W-1:0]};
        end
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      out_fp_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      out_fp_q <= out_fp_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_fp    = out_fp_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign dbg_state = state_q;

endmodule
